uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl.sv | 134 +++++++++++++
 tb/tb_uart_rx_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive frame controller (start/data/parity/stop sequencing)
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  Sampled_Bit,
  output logic                  dat_samp_en,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Parity_Error,
  output logic                  Stop_Error
);

  // Enough range for start + data + parity + stop bit positions.
  localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 4);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                  state;
  logic [BIT_CNT_W-1:0]    bit_cnt;
  logic [PRESCALE_W-1:0]   pre_q;
  logic                    par_en_q;
  logic                    par_typ_q;
  logic [DATA_WIDTH-1:0]   shift_q;
  logic                    par_err_q;

  logic [PRESCALE_W-1:0]   sample_pt;
  logic                    at_sp;
  logic                    at_wrap;
  logic                    stop_bad;
  logic                    par_fail;

  // The sampler's vote is valid a few cycles past mid-bit; timing uses the
  // prescale captured at frame start, never the live input.
  assign sample_pt = (pre_q >> 1) + PRESCALE_W'(3);
  assign at_sp     = (edge_cnt == sample_pt);
  assign at_wrap   = (edge_cnt == pre_q - PRESCALE_W'(1));
  assign stop_bad  = ~Sampled_Bit;
  assign par_fail  = par_en_q & par_err_q;

  // Frame FSM: bit timing counters, shift register, error flags and registered output pulses.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= IDLE;
      edge_cnt     <= '0;
      bit_cnt      <= '0;
      dat_samp_en  <= 1'b0;
      P_DATA       <= '0;
      Data_Valid   <= 1'b0;
      Parity_Error <= 1'b0;
      Stop_Error   <= 1'b0;
      pre_q        <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      shift_q      <= '0;
      par_err_q    <= 1'b0;
    end else begin
      Data_Valid   <= 1'b0;
      Parity_Error <= 1'b0;
      Stop_Error   <= 1'b0;
      case (state)
        IDLE: begin
          edge_cnt    <= '0;
          bit_cnt     <= '0;
          dat_samp_en <= 1'b0;
          if (!RX_IN) begin
            state       <= START;
            dat_samp_en <= 1'b1;
            pre_q       <= Prescale;
            par_en_q    <= PAR_EN;
            par_typ_q   <= PAR_TYP;
            shift_q     <= '0;
            par_err_q   <= 1'b0;
          end
        end
        default: begin
          if (at_wrap) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_cnt + 1'b1;
          end else begin
            edge_cnt <= edge_cnt + 1'b1;
          end
          case (state)
            START: begin
              // A start bit that reads high at mid-bit was line noise.
              if (at_sp && Sampled_Bit) begin
                state       <= IDLE;
                edge_cnt    <= '0;
                bit_cnt     <= '0;
                dat_samp_en <= 1'b0;
              end else if (at_wrap) begin
                state <= DATA;
              end
            end
            DATA: begin
              if (at_sp)
                shift_q <= {Sampled_Bit, shift_q[DATA_WIDTH-1:1]};
              if (at_wrap && bit_cnt == BIT_CNT_W'(DATA_WIDTH))
                state <= par_en_q ? PARITY : STOP;
            end
            PARITY: begin
              if (at_sp && (Sampled_Bit != ((^shift_q) ^ par_typ_q)))
                par_err_q <= 1'b1;
              if (at_wrap)
                state <= STOP;
            end
            STOP: begin
              if (at_sp) begin
                state        <= IDLE;
                edge_cnt     <= '0;
                bit_cnt      <= '0;
                dat_samp_en  <= 1'b0;
                Stop_Error   <= stop_bad;
                Parity_Error <= par_fail;
                Data_Valid   <= ~stop_bad & ~par_fail;
                if (!stop_bad && !par_fail)
                  P_DATA <= shift_q;
              end
            end
            default: ;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - randomized self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;
  localparam int DW = 8;
  localparam int PW = 6;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          RX_IN = 1'b1;
  logic [PW-1:0] Prescale = 6'd8;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic          Sampled_Bit = 1'b1;
  logic          dat_samp_en;
  logic [PW-1:0] edge_cnt;
  logic [DW-1:0] P_DATA;
  logic          Data_Valid;
  logic          Parity_Error;
  logic          Stop_Error;

  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] exp_pdata = '0;

  always #5 CLK = ~CLK;

  uart_rx_ctrl #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .Sampled_Bit(Sampled_Bit), .dat_samp_en(dat_samp_en),
    .edge_cnt(edge_cnt), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .Parity_Error(Parity_Error), .Stop_Error(Stop_Error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int rand_pre();
    case ($urandom_range(0, 2))
      0:       return 8;
      1:       return 16;
      default: return 32;
    endcase
  endfunction

  // Drives one frame on the line, starting at a negedge with the FSM idle.
  // The sampler model presents the vote for the bit the receiver is in, which
  // trails the line by the one cycle of start detection. Outputs are judged
  // from plain frame arithmetic: stop sample lands at 1 + (nb-1)*p + p/2 + 3.
  task automatic send_frame(input string tag, input logic [DW-1:0] data, input int p,
                            input bit pen, input bit ptyp, input bit flip,
                            input bit sbad, input int tail, input bit scramble,
                            input int abort_at);
    logic bits [0:DW+2];
    int   nb, sp, ns, total, k;
    int   dv_n, pe_n, se_n, first, ec_bad, en_bad, exp_ec;
    bit   exp_pe, exp_se, exp_dv;
    nb = pen ? DW + 3 : DW + 2;
    sp = p / 2 + 3;
    ns = 1 + (nb - 1) * p + sp;
    total = nb * p + tail;
    dv_n = 0; pe_n = 0; se_n = 0; first = -1; ec_bad = 0; en_bad = 0;
    exp_pe = pen && flip;
    exp_se = sbad;
    exp_dv = !exp_pe && !exp_se;
    bits[0] = 1'b0;
    for (int i = 0; i < DW; i++) bits[1 + i] = data[i];
    if (pen) bits[DW + 1] = (^data) ^ ptyp ^ flip;
    bits[nb - 1] = !sbad;
    for (int n = 0; n < total; n++) begin
      if (n == abort_at) begin
        #2 RST = 1'b0;
        #1;
        check({tag, "_rst_en"}, dat_samp_en, 0);
        check({tag, "_rst_ec"}, edge_cnt, 0);
        check({tag, "_rst_pdata"}, P_DATA, 0);
        check({tag, "_rst_pulses"}, {Data_Valid, Parity_Error, Stop_Error}, 0);
        exp_pdata = '0;
        RX_IN = 1'b1;
        Sampled_Bit = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        return;
      end
      k = n / p;
      RX_IN = (k < nb) ? bits[k] : 1'b1;
      if (sbad && k == nb - 1 && n > ns) RX_IN = 1'b1;
      Sampled_Bit = (n >= 1 && (n - 1) / p < nb) ? bits[(n - 1) / p] : 1'b1;
      if (n == 0 || !scramble) begin
        Prescale = PW'(p); PAR_EN = pen; PAR_TYP = ptyp;
      end else begin
        Prescale = PW'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
      end
      @(posedge CLK);
      #1;
      if (Data_Valid)   dv_n++;
      if (Parity_Error) pe_n++;
      if (Stop_Error)   se_n++;
      if (first < 0 && (Data_Valid || Parity_Error || Stop_Error)) first = n;
      exp_ec = (n < ns) ? n % p : 0;
      if (edge_cnt !== PW'(exp_ec)) ec_bad++;
      if (dat_samp_en !== (n < ns)) en_bad++;
      @(negedge CLK);
    end
    if (exp_dv) exp_pdata = data;
    check({tag, "_dv"}, dv_n, exp_dv);
    check({tag, "_perr"}, pe_n, exp_pe);
    check({tag, "_serr"}, se_n, exp_se);
    if (exp_dv || exp_pe || exp_se) check({tag, "_pulse_at"}, first, ns);
    check({tag, "_pdata"}, P_DATA, exp_pdata);
    check({tag, "_edge_cnt_bad"}, ec_bad, 0);
    check({tag, "_samp_en_bad"}, en_bad, 0);
  endtask

  // Two-cycle low blip with the sampler voting high.
  task automatic glitch();
    int pulses = 0;
    Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0; Sampled_Bit = 1'b1;
    for (int n = 0; n < 14; n++) begin
      RX_IN = (n < 2) ? 1'b0 : 1'b1;
      @(posedge CLK);
      #1;
      if (Data_Valid || Parity_Error || Stop_Error) pulses++;
      if (n == 7) begin
        check("glitch_ec7", edge_cnt, 7);
        check("glitch_en7", dat_samp_en, 1);
      end
      if (n == 8) begin
        check("glitch_ec_idle", edge_cnt, 0);
        check("glitch_en_idle", dat_samp_en, 0);
      end
      @(negedge CLK);
    end
    check("glitch_pulses", pulses, 0);
    check("glitch_pdata", P_DATA, exp_pdata);
  endtask

  initial begin
    int p, tail;
    repeat (3) @(negedge CLK);
    check("reset_pdata", P_DATA, 0);
    check("reset_en", dat_samp_en, 0);
    check("reset_ec", edge_cnt, 0);
    check("reset_pulses", {Data_Valid, Parity_Error, Stop_Error}, 0);
    RST = 1'b1;
    repeat (3) @(negedge CLK);

    send_frame("a5_p8", 8'hA5, 8, 0, 0, 0, 0, 3, 0, -1);
    send_frame("3c_par_ok", 8'h3C, 16, 1, 0, 0, 0, 3, 0, -1);
    send_frame("3c_par_bad", 8'h3C, 16, 1, 0, 1, 0, 3, 0, -1);
    send_frame("55_stop_bad", 8'h55, 8, 0, 0, 0, 1, 3, 0, -1);
    glitch();
    send_frame("b2b_01", 8'h01, 32, 1, 1, 0, 0, 0, 1, -1);
    send_frame("b2b_ff", 8'hFF, 32, 1, 1, 0, 0, 4, 1, -1);
    send_frame("abort", 8'h5A, 16, 0, 0, 0, 0, 3, 0, 5 * 16 + 8);
    send_frame("81_after_rst", 8'h81, 8, 0, 0, 0, 0, 3, 0, -1);

    for (int f = 0; f < 24; f++) begin
      p = rand_pre();
      tail = (p == 8) ? $urandom_range(2, 5) : $urandom_range(0, 5);
      send_frame($sformatf("rnd%0d", f), DW'($urandom), p, 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), tail, 1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
